// File: rtl/melody_sequencer.sv
// melody_sequencer
//   Plays a programmable table of {note code, duration} entries into the
//   speaker driver's 8-bit note-select input (0 = silence, 1..36 = notes).
//   Each note lasts (dur+1) tempo ticks. An optional silent gap of
//   GAP_TICKS ticks follows every note. Playback can be stopped, and it can
//   loop back to entry 0.
//
// Ports
//   clk, rst_n          : clock, asynchronous active-low reset
//   start, stop         : level controls; stop has priority over start
//   loop_en             : sampled when the last entry finishes; 1 = restart
//   seq_len             : entries to play, latched when start is accepted
//   wr_en/addr/note/dur : table write port, usable in any state
//   note                : note-select code to the speaker driver
//   busy                : high while a sequence is playing
//   done                : one-cycle pulse on normal completion
//   play_idx            : index of the current table entry
module melody_sequencer #(
    parameter int TICK_CYCLES = 6250000,
    parameter int GAP_TICKS   = 1,
    parameter int DEPTH       = 32,
    parameter int AW          = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          stop,
    input  logic          loop_en,
    input  logic [AW:0]   seq_len,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [5:0]    wr_note,
    input  logic [3:0]    wr_dur,
    output logic [7:0]    note,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] play_idx
);

    localparam int TW = $clog2(TICK_CYCLES);
    localparam int RW = 16;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);
    localparam logic [RW-1:0] GAP_LOAD  = RW'(GAP_TICKS);
    localparam logic [AW:0]   DEPTH_L   = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_NOTE,
        S_GAP
    } state_e;

    // Table word: {note code[5:0], duration[3:0]}. Not reset.
    logic [9:0] note_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            note_mem[wr_addr] <= {wr_note, wr_dur};
        end
    end

    state_e        state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [AW:0]   len_q, len_d;
    logic [7:0]    note_q, note_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [TW-1:0] tick_q, tick_d;
    logic [RW-1:0] rem_q, rem_d;

    logic [9:0]    fetch_word;
    logic [5:0]    fetch_code;
    logic          tick;
    logic          advance;
    logic [AW:0]   idx_inc;

    always_comb begin
        // The table word is captured into note_q/rem_q at the end of FETCH,
        // so a write landing on that same edge is not seen (old data wins).
        fetch_word = note_mem[idx_q];
        fetch_code = fetch_word[9:4];
        tick       = (tick_q == TICK_LAST);
        idx_inc    = {1'b0, idx_q} + (AW+1)'(1);
        advance    = 1'b0;

        state_d = state_q;
        idx_d   = idx_q;
        len_d   = len_q;
        note_d  = note_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        tick_d  = tick_q;
        rem_d   = rem_q;

        case (state_q)
            S_IDLE: begin
                note_d = 8'd0;
                busy_d = 1'b0;
                tick_d = '0;
                if (start && !stop) begin
                    len_d = (seq_len > DEPTH_L) ? DEPTH_L : seq_len;
                    if (len_d == '0) begin
                        done_d = 1'b1;
                    end else begin
                        idx_d   = '0;
                        busy_d  = 1'b1;
                        state_d = S_FETCH;
                    end
                end
            end
            S_FETCH: begin
                // Codes outside the three-octave range play as rests.
                note_d  = (fetch_code > 6'd36) ? 8'd0 : {2'b00, fetch_code};
                rem_d   = RW'(fetch_word[3:0]) + RW'(1);
                tick_d  = '0;
                state_d = S_NOTE;
            end
            S_NOTE: begin
                if (tick) begin
                    tick_d = '0;
                    rem_d  = rem_q - RW'(1);
                    if (rem_q == RW'(1)) begin
                        if (GAP_TICKS > 0) begin
                            note_d  = 8'd0;
                            rem_d   = GAP_LOAD;
                            state_d = S_GAP;
                        end else begin
                            advance = 1'b1;
                        end
                    end
                end else begin
                    tick_d = tick_q + TW'(1);
                end
            end
            S_GAP: begin
                if (tick) begin
                    tick_d = '0;
                    rem_d  = rem_q - RW'(1);
                    if (rem_q == RW'(1)) begin
                        advance = 1'b1;
                    end
                end else begin
                    tick_d = tick_q + TW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (advance) begin
            note_d = 8'd0;
            tick_d = '0;
            if (idx_inc < len_q) begin
                idx_d   = idx_q + AW'(1);
                state_d = S_FETCH;
            end else if (loop_en) begin
                idx_d   = '0;
                state_d = S_FETCH;
            end else begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
        end

        // Abort overrides everything else in any playing state.
        if (stop && state_q != S_IDLE) begin
            state_d = S_IDLE;
            note_d  = 8'd0;
            busy_d  = 1'b0;
            done_d  = 1'b0;
            idx_d   = '0;
            tick_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            len_q   <= '0;
            note_q  <= 8'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            tick_q  <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            note_q  <= note_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            tick_q  <= tick_d;
            rem_q   <= rem_d;
        end
    end

    assign note     = note_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign play_idx = idx_q;

endmodule

// File: tb/tb_melody_sequencer.sv
// Scoreboard bench for melody_sequencer. The driver builds the expected
// per-cycle output trace of each playback from the table contents and
// pushes it into exp_q; the monitor pops one entry per cycle and compares.
module tb_melody_sequencer;

    localparam int T     = 4;
    localparam int G     = 1;
    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic          clk     = 1'b0;
    logic          clk_en  = 1'b0;
    logic          rst_n   = 1'b1;
    logic          start   = 1'b0;
    logic          stop    = 1'b0;
    logic          loop_en = 1'b0;
    logic [AW:0]   seq_len = '0;
    logic          wr_en   = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [5:0]    wr_note = '0;
    logic [3:0]    wr_dur  = '0;
    logic [7:0]    note;
    logic          busy;
    logic          done;
    logic [AW-1:0] play_idx;

    melody_sequencer #(
        .TICK_CYCLES(T),
        .GAP_TICKS  (G),
        .DEPTH      (DEPTH),
        .AW         (AW)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .stop    (stop),
        .loop_en (loop_en),
        .seq_len (seq_len),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_note (wr_note),
        .wr_dur  (wr_dur),
        .note    (note),
        .busy    (busy),
        .done    (done),
        .play_idx(play_idx)
    );

    always #5 if (clk_en) clk = ~clk;

    typedef struct packed {
        logic [7:0]    note;
        logic          busy;
        logic          done;
        logic [AW-1:0] idx;
    } obs_t;

    obs_t  exp_q[$];
    obs_t  trace[$];
    int    total = 0;
    int    bad   = 0;
    string phase = "reset";

    int mcode [DEPTH];
    int mdur  [DEPTH];
    int last_idx = 0;

    function automatic obs_t mk(input int n, input int b, input int d, input int i);
        obs_t o;
        o.note = 8'(n);
        o.busy = 1'(b);
        o.done = 1'(d);
        o.idx  = AW'(i);
        return o;
    endfunction

    task automatic add(input int n, input int nt, input int b, input int d, input int i);
        for (int k = 0; k < n; k++) trace.push_back(mk(nt, b, d, i));
    endtask

    // Monitor: one comparison per cycle while expectations are queued.
    initial begin
        obs_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                total++;
                if (note !== e.note || busy !== e.busy || done !== e.done || play_idx !== e.idx) begin
                    bad++;
                    $display("FAIL %s: got note=%0d busy=%0b done=%0b idx=%0d, want note=%0d busy=%0b done=%0b idx=%0d",
                             phase, note, busy, done, play_idx, e.note, e.busy, e.done, e.idx);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, got, want);
        end
    endtask

    task automatic drain(input int limit);
        int k;
        k = 0;
        while (exp_q.size() > 0 && k < limit) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (exp_q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain %s: %0d samples never observed", phase, exp_q.size());
            exp_q.delete();
        end
    endtask

    // Called at posedge+1; leaves the bench at posedge+1.
    task automatic wr(input int a, input int c, input int d);
        wr_en   = 1'b1;
        wr_addr = AW'(a);
        wr_note = 6'(c);
        wr_dur  = 4'(d);
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        mcode[a] = c;
        mdur[a]  = d;
    endtask

    // Expected trace from sample 0 (the cycle start is driven). A write
    // driven in sample w is seen by a fetch in sample f only if w < f.
    task automatic build(input int slen, input int passes, input int w_at,
                         input int w_a, input int w_c, input int w_d);
        int len, s, code;
        bit wpend;
        trace.delete();
        len   = (slen > DEPTH) ? DEPTH : slen;
        wpend = (w_at >= 0);
        trace.push_back(mk(0, 0, 0, last_idx));
        if (len == 0) begin
            trace.push_back(mk(0, 0, 1, last_idx));
        end else begin
            for (int p = 0; p < passes; p++) begin
                for (int i = 0; i < len; i++) begin
                    s = trace.size();
                    if (wpend && w_at < s) begin
                        mcode[w_a] = w_c;
                        mdur[w_a]  = w_d;
                        wpend = 1'b0;
                    end
                    code = (mcode[i] > 36) ? 0 : mcode[i];
                    add(1, 0, 1, 0, i);
                    add((mdur[i] + 1) * T, code, 1, 0, i);
                    add(G * T, 0, 1, 0, i);
                end
            end
            trace.push_back(mk(0, 0, 1, len - 1));
            last_idx = len - 1;
        end
        if (wpend) begin
            mcode[w_a] = w_c;
            mdur[w_a]  = w_d;
        end
    endtask

    task automatic run(input string name, input int slen, input int passes, input int stop_at,
                       input int w_at, input int w_a, input int w_c, input int w_d, input int rst_at);
        int n, pass_len, drop;
        phase   = name;
        loop_en = (passes > 1);
        build(slen, passes, w_at, w_a, w_c, w_d);
        pass_len = (trace.size() - 2) / passes;
        drop     = (passes > 1) ? (1 + pass_len + 2) : -1;
        if (stop_at >= 0) begin
            while (trace.size() > stop_at + 1) void'(trace.pop_back());
            last_idx = 0;
            add(4, 0, 0, 0, 0);
        end else if (rst_at >= 0) begin
            while (trace.size() > rst_at + 1) void'(trace.pop_back());
        end else begin
            add(3, 0, 0, 0, last_idx);
        end
        n = trace.size();
        $display("run %s: seq_len=%0d passes=%0d cycles=%0d", name, slen, passes, n);
        foreach (trace[k]) exp_q.push_back(trace[k]);
        seq_len = (AW+1)'(slen);
        for (int s = 0; s < n; s++) begin
            start = (s == 0);
            stop  = (s == stop_at);
            if (s == w_at) begin
                wr_en   = 1'b1;
                wr_addr = AW'(w_a);
                wr_note = 6'(w_c);
                wr_dur  = 4'(w_d);
            end else begin
                wr_en = 1'b0;
            end
            if (s == drop) loop_en = 1'b0;
            @(posedge clk);
            #1;
        end
        start   = 1'b0;
        stop    = 1'b0;
        wr_en   = 1'b0;
        loop_en = 1'b0;
        drain(4);
    endtask

    initial begin
        int slen, passes;

        // Asynchronous reset with the clock stopped.
        #1 rst_n = 1'b0;
        #3;
        chk("reset_note", 32'(note), 0);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_done", 32'(done), 0);
        chk("reset_idx", 32'(play_idx), 0);
        clk_en = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic three-entry sequence, then looping twice.
        wr(0, 1, 0);
        wr(1, 10, 1);
        wr(2, 36, 2);
        run("basic", 3, 1, -1, -1, 0, 0, 0, -1);
        run("loop", 3, 2, -1, -1, 0, 0, 0, -1);

        // Stop during entry 1 (its fetch is sample 10).
        run("stop", 3, 1, 13, -1, 0, 0, 0, -1);

        // start and stop together in IDLE: nothing happens.
        phase = "start_stop_idle";
        $display("run %s: start and stop held together", phase);
        add(0, 0, 0, 0, 0);
        for (int k = 0; k < 6; k++) exp_q.push_back(mk(0, 0, 0, last_idx));
        for (int s = 0; s < 6; s++) begin
            start = (s < 4);
            stop  = (s < 4);
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        stop  = 1'b0;
        drain(4);

        // Out-of-range code plays as a rest; zero length; oversize length.
        wr(0, 40, 1);
        run("rest", 1, 1, -1, -1, 0, 0, 0, -1);
        run("len0", 0, 1, -1, -1, 0, 0, 0, -1);
        for (int i = 0; i < DEPTH; i++) wr(i, int'($urandom_range(0, 63)), int'($urandom_range(0, 3)));
        run("len12", 12, 1, -1, -1, 0, 0, 0, -1);

        // Write entry 1 while entry 0 plays: the new value is heard.
        wr(0, 5, 1);
        wr(1, 7, 0);
        run("midwrite", 2, 1, -1, 4, 1, 20, 2, -1);
        // Write entry 1 in its own fetch cycle (sample 14): old data plays.
        run("wr_on_fetch", 2, 1, -1, 14, 1, 33, 0, -1);

        // Reset mid-note: outputs clear without a clock edge.
        run("rst_mid", 2, 1, -1, -1, 0, 0, 0, 3);
        rst_n = 1'b0;
        #1;
        chk("rstmid_note", 32'(note), 0);
        chk("rstmid_busy", 32'(busy), 0);
        chk("rstmid_done", 32'(done), 0);
        chk("rstmid_idx", 32'(play_idx), 0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        last_idx = 0;
        @(posedge clk);
        #1;
        run("after_rst", 2, 1, -1, -1, 0, 0, 0, -1);

        // Randomized tables, lengths and looping.
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < DEPTH; i++) wr(i, int'($urandom_range(0, 63)), int'($urandom_range(0, 7)));
            slen   = int'($urandom_range(0, 15));
            passes = (slen > 0 && $urandom_range(0, 1) == 1) ? 2 : 1;
            run($sformatf("rand%0d", r), slen, passes, -1, -1, 0, 0, 0, -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
